// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data memory share one
// MainMemory port, DM has priority with a streak limit to avoid IF starvation.
module mem_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int MAX_STREAK  = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_enable,
    output logic [31:0] mem_address,
    output logic [64:0] mem_serial,
    input  logic [31:0] mem_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  streak;
    logic        own_dm;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        grant_dm;
    logic        grant_if;
    logic        access_done;

    assign grant_dm    = dm_req && !(if_req && streak == 4'(MAX_STREAK));
    assign grant_if    = if_req && !grant_dm;
    assign access_done = (cnt == 4'(MEM_LATENCY - 1));

    // state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_dm || grant_if) state_nxt = ACCESS;
            ACCESS:  if (access_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from state and latched request
    always_comb begin
        mem_enable  = 1'b0;
        mem_address = '0;
        mem_serial  = '0;
        if_ack      = 1'b0;
        dm_ack      = 1'b0;
        busy        = (state != IDLE);
        if (state == ACCESS) begin
            mem_enable  = 1'b1;
            mem_address = {2'b00, lat_addr[31:2]};
            mem_serial  = {lat_we, lat_addr, lat_wdata};
        end
        if (state == RESP) begin
            if_ack = !own_dm;
            dm_ack = own_dm;
        end
    end

    // grant latch, latency counter, streak counter and read-data capture
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            own_dm    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            streak    <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_dm) begin
                        own_dm    <= 1'b1;
                        lat_we    <= dm_we;
                        lat_addr  <= dm_addr;
                        lat_wdata <= dm_wdata;
                        cnt       <= '0;
                        if (!if_req)
                            streak <= '0;
                        else if (streak != 4'(MAX_STREAK))
                            streak <= streak + 4'd1;
                    end else if (grant_if) begin
                        own_dm    <= 1'b0;
                        lat_we    <= 1'b0;
                        lat_addr  <= if_addr;
                        lat_wdata <= '0;
                        cnt       <= '0;
                        streak    <= '0;
                    end
                end
                ACCESS: begin
                    if (access_done) begin
                        if (own_dm && !lat_we) dm_rdata <= mem_data;
                        else if (!own_dm)      if_rdata <= mem_data;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed transactions push the
// expected ack owner/read data, a negedge monitor pops on every ack.
module tb_mem_arbiter;

    typedef struct packed {
        logic        dm;
        logic [31:0] rd;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_enable;
    logic [31:0] mem_address;
    logic [64:0] mem_serial;
    logic [31:0] mem_data;
    logic        busy;

    logic        use_fn = 1'b0;
    logic [31:0] md_var = '0;
    logic [31:0] exp_if = '0;
    logic [31:0] exp_dm = '0;
    exp_t        sb[$];
    int          total = 0;
    int          passed = 0;

    function automatic logic [31:0] fmem(input logic [31:0] w);
        return {w[15:0], ~w[15:0]};
    endfunction

    assign mem_data = use_fn ? fmem(mem_address) : md_var;

    mem_arbiter #(.MEM_LATENCY(2), .MAX_STREAK(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_enable(mem_enable), .mem_address(mem_address),
        .mem_serial(mem_serial), .mem_data(mem_data), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passed++;
    endtask

    // ack monitor: each ack pulse must match the oldest expected response
    always @(negedge CLK) begin
        if (RESET_N && (if_ack || dm_ack)) begin
            exp_t e;
            total++;
            if (if_ack && dm_ack) begin
                $display("FAIL sb_both_acks: got if_ack=1 dm_ack=1 expected one");
            end else if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_ack: got ack dm=%0b expected none", dm_ack);
            end else begin
                e = sb.pop_front();
                if (e.dm !== dm_ack || e.rd !== (dm_ack ? dm_rdata : if_rdata))
                    $display("FAIL sb_ack: got dm=%0b rd=%h expected dm=%0b rd=%h",
                             dm_ack, dm_ack ? dm_rdata : if_rdata, e.dm, e.rd);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic txn(input bit dm, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] md);
        logic [64:0] ser;
        use_fn = 1'b0;
        md_var = md;
        if (dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        ser = dm ? {we, a, wd} : {1'b0, a, 32'h0};
        if (dm && !we) exp_dm = md;
        if (!dm)       exp_if = md;
        sb.push_back({dm, dm ? exp_dm : exp_if});
        tick();
        if_req = 1'b0; dm_req = 1'b0;
        dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom; if_addr = $urandom;
        for (int i = 0; i < 2; i++) begin
            chk("acc_enable", 65'(mem_enable), 65'(1));
            chk("acc_address", 65'(mem_address), 65'(a >> 2));
            chk("acc_serial", mem_serial, ser);
            chk("acc_busy", 65'(busy), 65'(1));
            tick();
        end
        chk("resp_enable", 65'(mem_enable), 65'(0));
        chk("resp_serial", mem_serial, 65'(0));
        chk("resp_address", 65'(mem_address), 65'(0));
        chk("resp_ack", 65'(dm ? dm_ack : if_ack), 65'(1));
        chk("resp_rdata", 65'(dm ? dm_rdata : if_rdata), 65'(dm ? exp_dm : exp_if));
        tick();
        chk("idle_busy", 65'(busy), 65'(0));
        chk("idle_acks", 65'({if_ack, dm_ack}), 65'(0));
        dm_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic prev_en;
        logic [31:0] order [10];

        // reset state
        #2;
        chk("rst_busy", 65'(busy), 65'(0));
        chk("rst_enable", 65'(mem_enable), 65'(0));
        chk("rst_serial", mem_serial, 65'(0));
        chk("rst_rdata", 65'({if_rdata, dm_rdata}), 65'(0));
        chk("rst_acks", 65'({if_ack, dm_ack}), 65'(0));
        tick();
        RESET_N = 1'b1;
        tick();

        // IF read, DM read, DM write
        txn(1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_FFFF);
        txn(1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'hCAFE_BABE);
        chk("if_rdata_hold", 65'(if_rdata), 65'(32'h0000_FFFF));
        txn(1'b1, 1'b1, 32'h0000_0008, 32'h0000_FFFF, 32'h1234_5678);
        chk("dm_rdata_wr_hold", 65'(dm_rdata), 65'(32'hCAFE_BABE));

        // simultaneous requests: DM first, IF four cycles later
        use_fn = 1'b1;
        if_req = 1'b1; if_addr = 32'h20;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
        exp_dm = fmem(32'hC);
        exp_if = fmem(32'h8);
        sb.push_back({1'b1, exp_dm});
        sb.push_back({1'b0, exp_if});
        tick();
        dm_req = 1'b0;
        chk("arb_dm_first", 65'(mem_address), 65'(32'hC));
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 4) begin
                chk("arb_if_grant", 65'({mem_enable, mem_address}), 65'({1'b1, 32'h8}));
                if_req = 1'b0;
            end
            chk("arb_dm_ack", 65'(dm_ack), 65'(k == 2));
            chk("arb_if_ack", 65'(if_ack), 65'(k == 6));
        end

        // both held: DM,DM,DM,DM,IF repeating
        dm_addr = 32'h100; dm_we = 1'b0; if_addr = 32'h200;
        exp_dm = fmem(32'h40);
        exp_if = fmem(32'h80);
        for (int i = 0; i < 10; i++) begin
            order[i] = (i % 5 != 4) ? 32'h40 : 32'h80;
            sb.push_back({(i % 5 != 4), (i % 5 != 4) ? exp_dm : exp_if});
        end
        dm_req = 1'b1; if_req = 1'b1;
        n = 0;
        prev_en = 1'b0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            tick();
            if (mem_enable && !prev_en) begin
                chk("streak_order", 65'(mem_address), 65'(order[n]));
                n++;
                if (n == 10) begin
                    dm_req = 1'b0; if_req = 1'b0;
                end
            end
            prev_en = mem_enable;
        end
        chk("streak_count", 65'(n), 65'(10));
        repeat (3) tick();
        chk("streak_idle", 65'(busy), 65'(0));

        // reset in the middle of a DM write access
        use_fn = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h44; dm_wdata = 32'h11;
        tick();
        dm_req = 1'b0; dm_we = 1'b0;
        chk("rst_mid_we", 65'(mem_serial[64]), 65'(1));
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_mid_enable", 65'(mem_enable), 65'(0));
        chk("rst_mid_we0", 65'(mem_serial[64]), 65'(0));
        chk("rst_mid_busy", 65'(busy), 65'(0));
        chk("rst_mid_ack", 65'(dm_ack), 65'(0));
        chk("rst_mid_rdata", 65'({if_rdata, dm_rdata}), 65'(0));
        tick();
        RESET_N = 1'b1;
        exp_dm = '0;
        exp_if = '0;
        repeat (4) tick();
        chk("rst_after_busy", 65'(busy), 65'(0));

        // DM request dropped one cycle after grant
        use_fn = 1'b1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        exp_dm = fmem(32'hC0);
        sb.push_back({1'b1, exp_dm});
        tick();
        tick();
        dm_req = 1'b0;
        tick();
        chk("drop_ack", 65'(dm_ack), 65'(1));
        tick();
        chk("drop_ack_once", 65'(dm_ack), 65'(0));
        tick();
        chk("drop_no_regrant", 65'(busy), 65'(0));
        chk("drop_rdata", 65'(dm_rdata), 65'(fmem(32'hC0)));

        repeat (3) tick();
        chk("sb_empty", 65'(sb.size()), 65'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 2, meaning cycles mem_enable is held per access (legal range 1..15).
REQ-002 The block SHALL have parameter MAX_STREAK, default 4, meaning consecutive DM grants allowed while IF waits (legal range 1..15).
REQ-003 The block SHALL have port CLK, input, width 1: the single clock, rising edge.
REQ-004 The block SHALL have port RESET_N, input, width 1: asynchronous active-low reset.
REQ-005 The block SHALL have port if_req, input, width 1: instruction-fetch read request.
REQ-006 The block SHALL have port if_addr, input, width 32: IF byte address.
REQ-007 The block SHALL have port if_rdata, output, width 32: IF read data.
REQ-008 The block SHALL have port if_ack, output, width 1: one-cycle IF completion pulse.
REQ-009 The block SHALL have port dm_req, input, width 1: data-memory request.
REQ-010 The block SHALL have port dm_we, input, width 1: DM write (1) / read (0).
REQ-011 The block SHALL have ports dm_addr and dm_wdata, input, width 32 each: DM byte address and write data.
REQ-012 The block SHALL have port dm_rdata, output, width 32: DM read data.
REQ-013 The block SHALL have port dm_ack, output, width 1: one-cycle DM completion pulse.
REQ-014 The block SHALL have port mem_enable, output, width 1: MainMemory enable.
REQ-015 The block SHALL have port mem_address, output, width 32: word address, latched byte address >> 2.
REQ-016 The block SHALL have port mem_serial, output, width 65: {we, byte address[31:0], wdata[31:0]}.
REQ-017 The block SHALL have port mem_data, input, width 32: MainMemory read data.
REQ-018 The block SHALL have port busy, output, width 1: high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-020 In IDLE, at a rising edge with any request high, the FSM SHALL latch owner, address, we and wdata and move to ACCESS (the grant edge, E0).
REQ-021 ACCESS SHALL last exactly MEM_LATENCY cycles, with mem_enable=1 and mem_address/mem_serial driven from latched values.
REQ-022 At edge E0+MEM_LATENCY the FSM SHALL capture mem_data into the owner's rdata register (reads only) and move to RESP.
REQ-023 RESP SHALL assert the owner's ack for exactly one cycle, then return to IDLE unconditionally; minimum grant-to-grant period SHALL be MEM_LATENCY+2 cycles.
REQ-024 Outside ACCESS, mem_enable, mem_address and mem_serial SHALL be 0, so mem_serial[64] (write) is only 1 during an ACCESS owned by a DM write.
REQ-025 IF SHALL always be issued with we=0 and wdata=0.
REQ-026 Priority SHALL be DM over IF, except when the streak counter equals MAX_STREAK and if_req is high, in which case IF wins.
REQ-027 The streak counter SHALL increment on a DM grant with if_req high, and SHALL clear on an IF grant or on a DM grant with if_req low; it saturates at MAX_STREAK.
REQ-028 On a DM write, dm_rdata SHALL hold its previous value.
REQ-029 if_rdata and dm_rdata SHALL hold their values until the next read by the same requester.
REQ-030 Address bits [1:0] SHALL be dropped in mem_address and passed unchanged in mem_serial.
REQ-031 Request inputs SHALL be sampled only at the grant edge, and later changes SHALL NOT affect the transaction in flight.
REQ-032 A request dropped mid-transaction SHALL still complete and ack.
REQ-033 A request still high in the cycle after its ack SHALL be treated as a new request.

Reset
REQ-034 RESET_N low SHALL immediately, without waiting for CLK, force IDLE.
REQ-035 RESET_N low SHALL force mem_enable=0, mem_serial=0, mem_address=0, if_ack=0, dm_ack=0, busy=0, if_rdata=0, dm_rdata=0 and streak=0.
REQ-036 A transaction interrupted by reset SHALL be discarded with no ack, including mid-ACCESS.

Verification
REQ-037 The bench SHALL cover: IF read if_addr=0x00000008, mem_data=0x0000FFFF -> mem_address=0x00000002 for 2 cycles, if_ack at E0+2 for 1 cycle, if_rdata=0x0000FFFF.
REQ-038 The bench SHALL cover: DM write dm_addr=0x00000008, dm_wdata=0x0000FFFF -> mem_serial={1,0x00000008,0x0000FFFF} for 2 cycles, then 0, single dm_ack, dm_rdata unchanged.
REQ-039 The bench SHALL cover: if_req and dm_req rise on the same edge -> DM granted first, IF granted 4 cycles later, if_ack exactly 4 cycles after dm_ack.
REQ-040 The bench SHALL cover: dm_req and if_req both held high continuously -> grant order DM,DM,DM,DM,IF, repeating.
REQ-041 The bench SHALL cover: RESET_N pulsed low during ACCESS of a DM write -> mem_enable and mem_serial[64] go 0 before the next CLK edge, no dm_ack, busy=0.
REQ-042 The bench SHALL cover: dm_req dropped one cycle after the grant edge -> access still completes and dm_ack pulses once.
